decode_stage: RTL and testbench

//  Registered RV32I instruction-decode pipeline stage: accepts {pc, instr} from fetch via valid/ready,

---
 rtl/decode_pkg.sv | 76 +++++++
 rtl/decode_if.sv | 34 +++
 rtl/rv_decode_comb.sv | 162 ++++++++++++++++
 rtl/decode_stage.sv | 103 ++++++++++
 tb/tb_decode_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared types for the RV32I decode stage.
//   - opcode constants for the base integer instruction groups
//   - alu_op_t   : ALU operation codes consumed by execute
//   - dec_ctrl_t : decoded control bundle carried with every beat
//   - imm_fmt_t  : immediate encoding formats
//   - gen_imm    : sign-extended immediate for a given format
package decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_SLL    = 4'b0010,
        ALU_SLT    = 4'b0011,
        ALU_SLTU   = 4'b0100,
        ALU_SRL    = 4'b0101,
        ALU_SRA    = 4'b0110,
        ALU_XOR    = 4'b0111,
        ALU_OR     = 4'b1000,
        ALU_AND    = 4'b1001,
        ALU_MUL    = 4'b1010,
        ALU_MULH   = 4'b1011,
        ALU_MULHSU = 4'b1100,
        ALU_MULHU  = 4'b1101
    } alu_op_t;

    typedef struct packed {
        logic    mem_write;
        logic    reg_write;
        logic    alu_in1_src;  // 0: zero (LUI), 1: rs1 / pc chosen by execute
        logic    alu_in2_src;  // 1: rs2, 0: immediate
        alu_op_t alu_op;
        logic    mem_to_reg;
        logic    branch;
        logic    jump;
        logic    jump_reg;
        logic    illegal;
    } dec_ctrl_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_t fmt);
        logic [31:0] imm;
        imm = '0;
        case (fmt)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'h000};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_if.sv
// Handshake bundles on both sides of the decode stage.
//   decode_in_if  : fetch -> decode  {in_valid, in_ready, in_pc, in_instr}
//   decode_out_if : decode -> execute {out_valid, out_ready, out_pc, out_ctrl,
//                                      out_rs1, out_rs2, out_rd, out_imm}
// Valid/ready: a beat transfers on a rising clock edge where valid and ready
// are both high. The producer keeps valid and payload stable until that edge;
// ready may change freely and never depends on the producer waiting for it.
interface decode_in_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;

    modport master (output in_valid, in_pc, in_instr, input in_ready);
    modport slave  (input in_valid, in_pc, in_instr, output in_ready);
endinterface

interface decode_out_if #(parameter int XLEN = 32);
    import decode_pkg::*;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    dec_ctrl_t       out_ctrl;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;

    modport master (output out_valid, out_pc, out_ctrl, out_rs1, out_rs2, out_rd, out_imm,
                    input out_ready);
    modport slave  (input out_valid, out_pc, out_ctrl, out_rs1, out_rs2, out_rd, out_imm,
                    output out_ready);
endinterface

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I(+M) decoder.
//   i_instr : raw instruction word
//   o_ctrl  : decoded control bundle (illegal encodings have side effects cleared)
//   o_rs1/o_rs2/o_rd : register index fields, always the raw instruction fields
//   o_imm   : sign-extended immediate for the opcode's format, 0 for R-type/unknown
module rv_decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ENABLE_MUL = 0
) (
    input  logic [31:0]     i_instr,
    output dec_ctrl_t       o_ctrl,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_imm
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_shamt_ok;
    dec_ctrl_t  w_ctrl;
    imm_fmt_t   w_fmt;
    logic       w_bad;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    // Immediate shifts only accept the two upper-field patterns.
    assign w_shamt_ok = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);

    always_comb begin
        w_ctrl             = '0;
        w_ctrl.alu_in1_src = 1'b1;
        w_ctrl.alu_op      = ALU_ADD;
        w_fmt              = IMM_NONE;
        w_bad              = 1'b0;

        case (w_opcode)
            OPC_LOAD: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_fmt             = IMM_I;
                // Legal widths: LB LH LW LBU LHU.
                w_bad = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                w_ctrl.mem_write = 1'b1;
                w_fmt            = IMM_S;
                w_bad            = w_funct3[2] || (w_funct3[1:0] == 2'b11);
            end
            OPC_OP_IMM: begin
                w_ctrl.reg_write = 1'b1;
                w_fmt            = IMM_I;
                case (w_funct3)
                    3'b000: w_ctrl.alu_op = ALU_ADD;
                    3'b001: begin
                        w_ctrl.alu_op = ALU_SLL;
                        w_bad         = !w_shamt_ok;
                    end
                    3'b010: w_ctrl.alu_op = ALU_SLT;
                    3'b011: w_ctrl.alu_op = ALU_SLTU;
                    3'b100: w_ctrl.alu_op = ALU_XOR;
                    3'b101: begin
                        w_ctrl.alu_op = i_instr[30] ? ALU_SRA : ALU_SRL;
                        w_bad         = !w_shamt_ok;
                    end
                    3'b110: w_ctrl.alu_op = ALU_OR;
                    default: w_ctrl.alu_op = ALU_AND;
                endcase
            end
            OPC_OP: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_in2_src = 1'b1;
                case (w_funct7)
                    F7_BASE: begin
                        case (w_funct3)
                            3'b000: w_ctrl.alu_op = ALU_ADD;
                            3'b001: w_ctrl.alu_op = ALU_SLL;
                            3'b010: w_ctrl.alu_op = ALU_SLT;
                            3'b011: w_ctrl.alu_op = ALU_SLTU;
                            3'b100: w_ctrl.alu_op = ALU_XOR;
                            3'b101: w_ctrl.alu_op = ALU_SRL;
                            3'b110: w_ctrl.alu_op = ALU_OR;
                            default: w_ctrl.alu_op = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        case (w_funct3)
                            3'b000: w_ctrl.alu_op = ALU_SUB;
                            3'b101: w_ctrl.alu_op = ALU_SRA;
                            default: w_bad = 1'b1;
                        endcase
                    end
                    F7_MULDIV: begin
                        // funct3[2]=1 is DIV/REM, never supported here.
                        if ((ENABLE_MUL != 0) && !w_funct3[2]) begin
                            case (w_funct3[1:0])
                                2'b00: w_ctrl.alu_op = ALU_MUL;
                                2'b01: w_ctrl.alu_op = ALU_MULH;
                                2'b10: w_ctrl.alu_op = ALU_MULHSU;
                                default: w_ctrl.alu_op = ALU_MULHU;
                            endcase
                        end else begin
                            w_bad = 1'b1;
                        end
                    end
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_LUI: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_in1_src = 1'b0;
                w_fmt              = IMM_U;
            end
            OPC_AUIPC: begin
                w_ctrl.reg_write = 1'b1;
                w_fmt            = IMM_U;
            end
            OPC_JAL: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.jump      = 1'b1;
                w_fmt            = IMM_J;
            end
            OPC_JALR: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.jump_reg  = 1'b1;
                w_fmt            = IMM_I;
                w_bad            = (w_funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                w_ctrl.branch      = 1'b1;
                w_ctrl.alu_in2_src = 1'b1;
                w_ctrl.alu_op      = ALU_SUB;
                w_fmt              = IMM_B;
                w_bad              = (w_funct3[2:1] == 2'b01);
            end
            // Also covers every word whose low two bits are not 2'b11.
            default: w_bad = 1'b1;
        endcase

        // Illegal beats still flow downstream but must not cause side effects.
        if (w_bad) begin
            w_ctrl.reg_write = 1'b0;
            w_ctrl.mem_write = 1'b0;
            w_ctrl.branch    = 1'b0;
            w_ctrl.jump      = 1'b0;
            w_ctrl.jump_reg  = 1'b0;
            w_ctrl.alu_op    = ALU_ADD;
        end
        w_ctrl.illegal = w_bad;
    end

    assign o_ctrl = w_ctrl;
    assign o_rs1  = i_instr[19:15];
    assign o_rs2  = i_instr[24:20];
    assign o_rd   = i_instr[11:7];
    assign o_imm  = gen_imm(i_instr, w_fmt);

endmodule

// File: rtl/decode_stage.sv
// Registered decode pipeline stage between fetch and execute.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   flush      : drop every held beat and the beat offered in the same cycle
//   fetch      : decode_in_if.slave  (in_valid/in_ready/in_pc/in_instr)
//   exec       : decode_out_if.master (out_valid/out_ready/decoded payload)
// Instructions are decoded on the way in, so both buffer entries hold decoded
// data. With SKID=1 a second entry catches the beat accepted while execute
// stalls, which lets in_ready come straight from a flop.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ENABLE_MUL = 0,
    parameter int SKID       = 1
) (
    input logic          clk,
    input logic          rst_n,
    input logic          flush,
    decode_in_if.slave   fetch,
    decode_out_if.master exec
);

    if (XLEN != 32) begin : g_xlen_check
        $error("decode_stage: only XLEN=32 is supported");
    end

    typedef struct packed {
        logic [XLEN-1:0] pc;
        dec_ctrl_t       ctrl;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
    } entry_t;

    entry_t w_in;
    entry_t r_main;
    entry_t r_skid;
    logic   r_main_valid;
    logic   r_skid_valid;
    logic   w_accept;
    logic   w_main_free;

    rv_decode_comb #(
        .XLEN       (XLEN),
        .ENABLE_MUL (ENABLE_MUL)
    ) u_dec (
        .i_instr (fetch.in_instr),
        .o_ctrl  (w_in.ctrl),
        .o_rs1   (w_in.rs1),
        .o_rs2   (w_in.rs2),
        .o_rd    (w_in.rd),
        .o_imm   (w_in.imm)
    );
    assign w_in.pc = fetch.in_pc;

    if (SKID != 0) begin : g_skid_ready
        assign fetch.in_ready = ~r_skid_valid;
    end else begin : g_single_ready
        assign fetch.in_ready = ~r_main_valid | exec.out_ready;
    end

    assign w_accept    = fetch.in_valid & fetch.in_ready;
    // Main entry can be (re)loaded when empty or being consumed this cycle.
    assign w_main_free = ~r_main_valid | exec.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            // in_ready is low whenever the skid is full, so a skid drain and
            // a new accept never happen in the same cycle.
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_accept;
                if (w_accept) begin
                    r_main <= w_in;
                end
            end
        end else if (w_accept && (SKID != 0)) begin
            r_skid       <= w_in;
            r_skid_valid <= 1'b1;
        end
    end

    assign exec.out_valid = r_main_valid;
    assign exec.out_pc    = r_main.pc;
    assign exec.out_ctrl  = r_main.ctrl;
    assign exec.out_rs1   = r_main.rs1;
    assign exec.out_rs2   = r_main.rs2;
    assign exec.out_rd    = r_main.rd;
    assign exec.out_imm   = r_main.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (M extension off / on) share one
// input stream and one out_ready. Expected beats come from a reference
// decoder written directly from the instruction-set rules.
module tb_decode_stage;
    import decode_pkg::*;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        drv_valid = 1'b0;
    logic [31:0] drv_pc = '0;
    logic [31:0] drv_instr = '0;
    logic        drv_ordy = 1'b0;

    int checks = 0;
    int errors = 0;
    int pop_count = 0;

    logic [91:0] exp_q0[$];
    logic [91:0] exp_q1[$];

    always #5 clk = ~clk;

    decode_in_if  #(.XLEN(XLEN)) in0 ();
    decode_in_if  #(.XLEN(XLEN)) in1 ();
    decode_out_if #(.XLEN(XLEN)) out0 ();
    decode_out_if #(.XLEN(XLEN)) out1 ();

    assign in0.in_valid  = drv_valid;
    assign in0.in_pc     = drv_pc;
    assign in0.in_instr  = drv_instr;
    assign in1.in_valid  = drv_valid;
    assign in1.in_pc     = drv_pc;
    assign in1.in_instr  = drv_instr;
    assign out0.out_ready = drv_ordy;
    assign out1.out_ready = drv_ordy;

    decode_stage #(.XLEN(XLEN), .ENABLE_MUL(0), .SKID(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .fetch(in0), .exec(out0));
    decode_stage #(.XLEN(XLEN), .ENABLE_MUL(1), .SKID(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .fetch(in1), .exec(out1));

    logic [91:0] act0;
    logic [91:0] act1;
    assign act0 = {out0.out_pc, out0.out_ctrl, out0.out_rs1, out0.out_rs2, out0.out_rd, out0.out_imm};
    assign act1 = {out1.out_pc, out1.out_ctrl, out1.out_rs1, out1.out_rs2, out1.out_rd, out1.out_imm};

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic signed [31:0] t;
        t = $signed(v << (32 - bits));
        return t >>> (32 - bits);
    endfunction

    function automatic logic [12:0] mk_ctrl(input bit mw, input bit rw, input bit s1, input bit s2,
                                            input logic [3:0] op, input bit m2r, input bit br,
                                            input bit j, input bit jr, input bit ill);
        return {mw, rw, s1, s2, op, m2r, br, j, jr, ill};
    endfunction

    // Returns {ctrl[12:0], rs1, rs2, rd, imm[31:0]}.
    function automatic logic [59:0] ref_decode(input logic [31:0] ins, input bit en_mul);
        int          base_op[8];
        logic [2:0]  f3;
        logic [6:0]  f7;
        bit          wr, mw, s1, s2, m2r, br, jp, jr, ill;
        int          op;
        logic [31:0] imm;
        base_op = '{0, 2, 3, 4, 7, 5, 8, 9};
        f3 = ins[14:12];
        f7 = ins[31:25];
        wr = 0; mw = 0; s1 = 1; s2 = 0; m2r = 0; br = 0; jp = 0; jr = 0; ill = 0;
        op = 0;
        imm = 0;
        case (ins[6:0])
            7'h03: begin
                wr = 1; m2r = 1; imm = sext(ins[31:20], 12);
                ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            end
            7'h23: begin
                mw = 1; imm = sext({ins[31:25], ins[11:7]}, 12);
                ill = (f3 > 2);
            end
            7'h13: begin
                wr = 1; imm = sext(ins[31:20], 12);
                if (f3 == 1 || f3 == 5) begin
                    ill = !(f7 == 7'h00 || f7 == 7'h20);
                    op = (f3 == 1) ? 2 : (ins[30] ? 6 : 5);
                end else begin
                    op = base_op[f3];
                end
            end
            7'h33: begin
                wr = 1; s2 = 1;
                if (f7 == 7'h00) op = base_op[f3];
                else if (f7 == 7'h20 && f3 == 0) op = 1;
                else if (f7 == 7'h20 && f3 == 5) op = 6;
                else if (f7 == 7'h01 && en_mul && f3 < 4) op = 10 + f3;
                else ill = 1;
            end
            7'h37: begin wr = 1; s1 = 0; imm = {ins[31:12], 12'h000}; end
            7'h17: begin wr = 1; imm = {ins[31:12], 12'h000}; end
            7'h6F: begin
                wr = 1; jp = 1;
                imm = sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
            end
            7'h67: begin
                wr = 1; jr = 1; imm = sext(ins[31:20], 12);
                ill = (f3 != 0);
            end
            7'h63: begin
                br = 1; s2 = 1; op = 1;
                imm = sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
                ill = (f3 == 2 || f3 == 3);
            end
            default: ill = 1;
        endcase
        if (ill) begin
            wr = 0; mw = 0; br = 0; jp = 0; jr = 0; op = 0;
        end
        return {mk_ctrl(mw, wr, s1, s2, op[3:0], m2r, br, jp, jr, ill),
                ins[19:15], ins[24:20], ins[11:7], imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs[9];
        logic [6:0]  f7s[3];
        logic [31:0] r;
        int          k;
        opcs = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63};
        f7s  = '{7'h00, 7'h20, 7'h01};
        r = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) begin
            r[6:0] = opcs[k];
            if ((k == 2 || k == 3) && $urandom_range(0, 3) != 0)
                r[31:25] = f7s[$urandom_range(0, 2)];
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    // One cycle of stimulus; the beat is recorded as expected once it has
    // actually been taken at the clock edge.
    task automatic drive_cycle(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                               input bit ordy, input bit fl, output bit acc);
        @(negedge clk);
        drv_valid = v;
        drv_pc    = pc;
        drv_instr = instr;
        drv_ordy  = ordy;
        flush     = fl;
        #1;
        acc = v && in0.in_ready && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q0.delete();
            exp_q1.delete();
        end
        if (acc) begin
            exp_q0.push_back({pc, ref_decode(instr, 1'b0)});
            exp_q1.push_back({pc, ref_decode(instr, 1'b1)});
        end
        drv_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(0, 32'h0, 32'h0, ordy, 0, acc);
    endtask

    // Send one beat with out_ready=1 and check the spec-listed fields one cycle later.
    task automatic directed(input string name, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [12:0] ctrl0, input logic [12:0] ctrl1,
                            input logic [31:0] imm);
        bit acc;
        drive_cycle(1, pc, instr, 1, 0, acc);
        check({name, "_acc"}, acc, 1);
        @(negedge clk);
        #1;
        check({name, "_valid"}, out0.out_valid, 1);
        check({name, "_ctrl0"}, out0.out_ctrl, ctrl0);
        check({name, "_ctrl1"}, out1.out_ctrl, ctrl1);
        check({name, "_imm"}, out0.out_imm, imm);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        bit          stall0 = 0;
        bit          stall1 = 0;
        logic [91:0] held0 = '0;
        logic [91:0] held1 = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stall0 = 0;
                stall1 = 0;
            end else begin
                check("in_ready0", in0.in_ready, exp_q0.size() < 2);
                check("in_ready1", in1.in_ready, exp_q1.size() < 2);
                check("out_valid0", out0.out_valid, exp_q0.size() != 0);
                check("out_valid1", out1.out_valid, exp_q1.size() != 0);
                if (stall0) check("stable0", act0, held0);
                if (stall1) check("stable1", act1, held1);
                if (out0.out_valid && drv_ordy && !flush && exp_q0.size() != 0) begin
                    check("beat0", act0, exp_q0.pop_front());
                    pop_count++;
                end
                if (out1.out_valid && drv_ordy && !flush && exp_q1.size() != 0)
                    check("beat1", act1, exp_q1.pop_front());
                stall0 = out0.out_valid && !drv_ordy && !flush;
                stall1 = out1.out_valid && !drv_ordy && !flush;
                held0  = act0;
                held1  = act1;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main_seq
        bit          acc;
        bit          have;
        int          n_acc;
        int          pops_before;
        logic [31:0] pc;
        logic [31:0] instr;

        // Reset state
        #12;
        check("rst_out_valid", out0.out_valid, 0);
        check("rst_in_ready", in0.in_ready, 1);
        check("rst_data", act0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed decodes
        directed("add", 32'h100, 32'h002081B3,
                 mk_ctrl(0, 1, 1, 1, 4'b0000, 0, 0, 0, 0, 0),
                 mk_ctrl(0, 1, 1, 1, 4'b0000, 0, 0, 0, 0, 0), 32'h0);
        check("add_rd", out0.out_rd, 3);
        check("add_rs1", out0.out_rs1, 1);
        check("add_rs2", out0.out_rs2, 2);
        check("add_pc", out0.out_pc, 32'h100);
        directed("addi", 32'h104, 32'hFFF00093,
                 mk_ctrl(0, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 0),
                 mk_ctrl(0, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 0), 32'hFFFFFFFF);
        directed("srai", 32'h108, 32'h4032D293,
                 mk_ctrl(0, 1, 1, 0, 4'b0110, 0, 0, 0, 0, 0),
                 mk_ctrl(0, 1, 1, 0, 4'b0110, 0, 0, 0, 0, 0), 32'h00000403);
        directed("lw", 32'h10C, 32'h0080A283,
                 mk_ctrl(0, 1, 1, 0, 4'b0000, 1, 0, 0, 0, 0),
                 mk_ctrl(0, 1, 1, 0, 4'b0000, 1, 0, 0, 0, 0), 32'h8);
        directed("sw", 32'h110, 32'hFE50AE23,
                 mk_ctrl(1, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 0),
                 mk_ctrl(1, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 0), 32'hFFFFFFFC);
        directed("zero", 32'h114, 32'h00000000,
                 mk_ctrl(0, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 1),
                 mk_ctrl(0, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 1), 32'h0);
        directed("mul", 32'h118, 32'h022081B3,
                 mk_ctrl(0, 0, 1, 1, 4'b0000, 0, 0, 0, 0, 1),
                 mk_ctrl(0, 1, 1, 1, 4'b1010, 0, 0, 0, 0, 0), 32'h0);
        directed("div", 32'h11C, 32'h0220C1B3,
                 mk_ctrl(0, 0, 1, 1, 4'b0000, 0, 0, 0, 0, 1),
                 mk_ctrl(0, 0, 1, 1, 4'b0000, 0, 0, 0, 0, 1), 32'h0);
        directed("beq", 32'h120, 32'hFE208EE3,
                 mk_ctrl(0, 0, 1, 1, 4'b0001, 0, 1, 0, 0, 0),
                 mk_ctrl(0, 0, 1, 1, 4'b0001, 0, 1, 0, 0, 0), 32'hFFFFFFFC);
        directed("lui", 32'h124, 32'h123452B7,
                 mk_ctrl(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0),
                 mk_ctrl(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0), 32'h12345000);
        idle(2, 1);

        // Stall: 4 beats offered, only 2 fit
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1, 32'h200 + 32'(n_acc * 4), 32'h00108093 + 32'(n_acc << 20), 0, 0, acc);
            if (acc) n_acc++;
        end
        check("stall_accepted", n_acc, 2);
        check("stall_in_ready", in0.in_ready, 0);
        pops_before = pop_count;
        while (n_acc < 4) begin
            drive_cycle(1, 32'h200 + 32'(n_acc * 4), 32'h00108093 + 32'(n_acc << 20), 1, 0, acc);
            if (acc) n_acc++;
            if (pop_count - pops_before > 20) break;
        end
        check("release_rate", pop_count - pops_before, n_acc - 1);
        idle(3, 1);
        check("release_drained", exp_q0.size(), 0);

        // Flush with both entries full and a beat offered
        drive_cycle(1, 32'h300, 32'h00500113, 0, 0, acc);
        drive_cycle(1, 32'h304, 32'h00600193, 0, 0, acc);
        check("flush_full", in0.in_ready, 0);
        drive_cycle(1, 32'h308, 32'h00700213, 0, 1, acc);
        @(negedge clk);
        #1;
        check("flush_out_valid", out0.out_valid, 0);
        check("flush_in_ready", in0.in_ready, 1);
        idle(4, 1);

        // Asynchronous reset mid-stream
        drive_cycle(1, 32'h400, 32'h00A00293, 0, 0, acc);
        drive_cycle(1, 32'h404, 32'h00B00313, 0, 0, acc);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out0.out_valid, 0);
        check("arst_in_ready", in0.in_ready, 1);
        check("arst_data", act0, 0);
        exp_q0.delete();
        exp_q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1);

        // Randomized traffic
        have  = 0;
        pc    = 32'h1000;
        instr = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            bit fl;
            bit ordy;
            if (!have && $urandom_range(0, 9) < 7) begin
                have  = 1;
                instr = rand_instr();
                pc    = pc + 4;
            end
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 59) == 0);
            drive_cycle(have, pc, instr, ordy, fl, acc);
            if (acc || fl) have = 0;
        end
        idle(5, 1);
        check("final_drain0", exp_q0.size(), 0);
        check("final_drain1", exp_q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
